// File: rtl/adc_capture_14bit_if.sv
// adc_capture_14bit_if
//   Valid/ready record stream leaving the ADC capture block.
//   data  : {B,A} decimated sample pair, each W-bit two's complement (or raw)
//   valid : data/last hold a word
//   ready : sink accepts the word this cycle
//   last  : word is the final pair of the captured record
//   master modport: producer (capture block); slave modport: consumer.
interface adc_capture_14bit_if #(
  parameter int W = 14
);
  logic [2*W-1:0] data;
  logic           valid;
  logic           ready;
  logic           last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/adc_capture_14bit.sv
// adc_capture_14bit
//   Receive side of the dual 14-bit converter board. Registers both ADC
//   channels, optionally converts offset-binary to two's complement, block-
//   averages by 2**DEC_LOG2, and on a rising crossing of trig_level on
//   channel A stores capture_len pairs into a first-word-fall-through FIFO
//   that drains over a valid/ready stream.
//
// Ports
//   clk          system clock, also forwarded as the converter sample clock
//   rst          synchronous active-high reset
//   adc_da/db    raw channel samples;   adc_otr_a/b  out-of-range flags
//   adc_clk_a/b  = clk;                 adc_oe_n     tied low
//   arm          one-cycle capture request (IDLE only, capture_len != 0)
//   abort        cancel capture and flush the FIFO (wins over arm)
//   trig_level   signed threshold on channel A
//   capture_len  record length in pairs, latched on an accepted arm
//   m            record stream {B,A}, last marks the final pair
//   busy         FSM not idle
//   done         one-cycle pulse on the pop of the final pair
//   ovf          sticky: a pair was dropped because the FIFO was full
//   otr_seen     sticky {B,A} out-of-range seen while capturing
//
// States
//   state   | meaning
//   IDLE    | waiting for arm
//   ARMED   | tracking previous decimated A, looking for a rising crossing
//   CAPTURE | pushing every decimated pair until len pairs are stored
//   DRAIN   | record complete, waiting for the last pair to be popped
module adc_capture_14bit #(
  parameter int W         = 14,
  parameter int DEC_LOG2  = 2,
  parameter int FIFO_AW   = 4,
  parameter int TWOS_COMP = 1,
  parameter int LEN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         adc_da,
  input  logic [W-1:0]         adc_db,
  input  logic                 adc_otr_a,
  input  logic                 adc_otr_b,
  output logic                 adc_clk_a,
  output logic                 adc_clk_b,
  output logic                 adc_oe_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [W-1:0]         trig_level,
  input  logic [LEN_W-1:0]     capture_len,
  adc_capture_14bit_if.master  m,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf,
  output logic [1:0]           otr_seen
);

  localparam int ACC_W = W + DEC_LOG2;
  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [W-1:0] MSB_FLIP =
    (TWOS_COMP != 0) ? {1'b1, {(W-1){1'b0}}} : '0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] PTR_ONE = {{FIFO_AW{1'b0}}, 1'b1};

  assign adc_clk_a = clk;
  assign adc_clk_b = clk;
  assign adc_oe_n  = 1'b0;

  // ---------------------------------------------------------------
  // Input pipeline: s1 captures the pins, s2 carries converted data.
  // ---------------------------------------------------------------
  logic [W-1:0] s1_a, s1_b, s2_a, s2_b;
  logic [1:0]   s1_otr, s2_otr;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_otr <= '0;
      s2_a   <= '0;
      s2_b   <= '0;
      s2_otr <= '0;
    end else begin
      s1_a   <= adc_da;
      s1_b   <= adc_db;
      s1_otr <= {adc_otr_b, adc_otr_a};
      s2_a   <= s1_a ^ MSB_FLIP;
      s2_b   <= s1_b ^ MSB_FLIP;
      s2_otr <= s1_otr;
    end
  end

  // ---------------------------------------------------------------
  // Control signals shared by decimator, FSM and FIFO
  // ---------------------------------------------------------------
  logic [1:0]         state;
  logic               arm_ok;
  logic               flush;

  assign arm_ok = arm && !abort && (state == S_IDLE) && (capture_len != '0);
  assign flush  = abort || arm_ok;

  // ---------------------------------------------------------------
  // Decimator
  // ---------------------------------------------------------------
  logic               dec_stb;
  logic signed [W-1:0] dec_a, dec_b;

  generate
    if (DEC_LOG2 == 0) begin : g_bypass
      assign dec_stb = 1'b1;
      assign dec_a   = s2_a;
      assign dec_b   = s2_b;
    end else begin : g_avg
      logic [DEC_LOG2-1:0] phase;
      logic [ACC_W-1:0]    acc_a, acc_b, sum_a, sum_b;

      assign sum_a   = acc_a + {{DEC_LOG2{s2_a[W-1]}}, s2_a};
      assign sum_b   = acc_b + {{DEC_LOG2{s2_b[W-1]}}, s2_b};
      assign dec_stb = &phase;
      // Dropping the low DEC_LOG2 bits is an arithmetic shift, i.e. a
      // floor division of the signed block sum.
      assign dec_a   = sum_a[ACC_W-1:DEC_LOG2];
      assign dec_b   = sum_b[ACC_W-1:DEC_LOG2];

      always_ff @(posedge clk) begin
        if (rst || arm_ok) begin
          phase <= '0;
          acc_a <= '0;
          acc_b <= '0;
        end else begin
          phase <= phase + {{(DEC_LOG2-1){1'b0}}, 1'b1};
          if (dec_stb) begin
            acc_a <= '0;
            acc_b <= '0;
          end else begin
            acc_a <= sum_a;
            acc_b <= sum_b;
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------
  // FIFO (first-word fall-through, extra pointer bit for full/empty)
  // ---------------------------------------------------------------
  logic [2*W:0]     mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [2*W:0]     rd_word;
  logic             fifo_empty, fifo_full;
  logic             pop, push_req, push_ok, push_last;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                      (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign rd_word    = mem[rd_ptr[FIFO_AW-1:0]];

  assign m.valid = !fifo_empty;
  // Outputs read as zero when nothing is queued so an idle or freshly
  // reset block never shows stale memory contents.
  assign m.data  = m.valid ? rd_word[2*W-1:0] : '0;
  assign m.last  = m.valid && rd_word[2*W];

  assign pop     = m.valid && m.ready;
  assign push_ok = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[FIFO_AW-1:0]] <= {push_last, dec_b, dec_a};
  end

  // ---------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------
  logic [LEN_W-1:0]    len_q, count;
  logic                have_prev;
  logic signed [W-1:0] prev_a;
  logic                crossing;

  assign crossing  = have_prev && (prev_a < $signed(trig_level)) &&
                     (dec_a >= $signed(trig_level));
  assign push_req  = !abort && dec_stb &&
                     (((state == S_ARMED) && crossing) || (state == S_CAPTURE));
  assign push_last = (count == (len_q - LEN_ONE));
  assign done      = !abort && (state == S_DRAIN) && pop && rd_word[2*W];
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      count     <= '0;
      have_prev <= 1'b0;
      prev_a    <= '0;
      ovf       <= 1'b0;
      otr_seen  <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (arm_ok) begin
            state     <= S_ARMED;
            len_q     <= capture_len;
            count     <= '0;
            have_prev <= 1'b0;
            ovf       <= 1'b0;
            otr_seen  <= '0;
          end
        end
        S_ARMED: begin
          if (dec_stb) begin
            if (crossing) begin
              state <= S_CAPTURE;
            end else begin
              prev_a    <= dec_a;
              have_prev <= 1'b1;
            end
          end
        end
        S_CAPTURE: begin
          otr_seen <= otr_seen | s2_otr;
        end
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // The crossing pair is the first push, so a length-1 record can
      // go from ARMED straight to DRAIN; this later assignment wins.
      if (push_req) begin
        if (push_ok) begin
          count <= count + LEN_ONE;
          if (push_last) state <= S_DRAIN;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_14bit.sv
module tb_adc_capture_14bit;
  localparam int W     = 14;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] adc_da = '0, adc_db = '0;
  logic adc_otr_a = 1'b0, adc_otr_b = 1'b0;
  logic adc_clk_a, adc_clk_b, adc_oe_n;
  logic arm = 1'b0, abort = 1'b0;
  logic [W-1:0] trig_level = '0;
  logic [15:0]  capture_len = '0;
  logic busy, done, ovf;
  logic [1:0] otr_seen;

  adc_capture_14bit_if #(.W(W)) m_if ();

  adc_capture_14bit #(
    .W(W), .DEC_LOG2(2), .FIFO_AW(4), .TWOS_COMP(1), .LEN_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .adc_da(adc_da), .adc_db(adc_db),
    .adc_otr_a(adc_otr_a), .adc_otr_b(adc_otr_b),
    .adc_clk_a(adc_clk_a), .adc_clk_b(adc_clk_b), .adc_oe_n(adc_oe_n),
    .arm(arm), .abort(abort),
    .trig_level(trig_level), .capture_len(capture_len),
    .m(m_if),
    .busy(busy), .done(done), .ovf(ovf), .otr_seen(otr_seen)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc = 0;
  int pin_a [8192];
  int pin_b [8192];
  int mode = 0;            // 0 constant, 1 ramp on A, 2 random
  int ramp_v = 0;
  logic [W-1:0] cval_a = '0, cval_b = '0;
  bit rnd_ready = 1'b0;
  int arm_cyc = 0;

  logic [2*W-1:0] got_d[$];
  logic           got_l[$];
  int             done_cnt = 0;
  int             stab_err = 0;
  logic           hold_v = 1'b0;
  logic [2*W-1:0] hold_d;
  logic           hold_l;

  logic [2*W-1:0] exp_d[$];
  logic           exp_ovf;

  // Stream observer: beats, done pulses and hold-stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && m_if.valid && (m_if.data !== hold_d || m_if.last !== hold_l))
        stab_err++;
      if (m_if.valid && m_if.ready) begin
        got_d.push_back(m_if.data);
        got_l.push_back(m_if.last);
      end
      if (done) done_cnt++;
      hold_v = m_if.valid && !m_if.ready;
      hold_d = m_if.data;
      hold_l = m_if.last;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: inputs for cycle 'cyc' are applied 1 time unit after
  // its rising edge and recorded for the reference model.
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    case (mode)
      0: begin adc_da = cval_a; adc_db = cval_b; end
      1: begin adc_da = W'(ramp_v) ^ 14'h2000; ramp_v++; adc_db = W'($urandom); end
      default: begin adc_da = W'($urandom); adc_db = W'($urandom); end
    endcase
    if (rnd_ready) m_if.ready = 1'($urandom_range(0, 1));
    if (cyc < 8192) begin
      pin_a[cyc] = int'(adc_da);
      pin_b[cyc] = int'(adc_db);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Reference model: offset-binary pin -> signed value, 4-sample block
  // average with floor, first block seeds prev, rising crossing starts the
  // record; with the sink stalled, at most DEPTH pairs fit until ready rises.
  function automatic int conv(input int raw);
    int v;
    v = raw ^ 'h2000;
    if (v >= 8192) v = v - 16384;
    return v;
  endfunction

  function automatic int blk(input bit chan_b, input int a, input int k);
    int s, idx;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      idx = a - 1 + 4 * k + j;
      if (idx >= 0 && idx < 8192) s += conv(chan_b ? pin_b[idx] : pin_a[idx]);
    end
    return s >>> 2;
  endfunction

  task automatic build_model(input int a, input int len, input int trig, input int r);
    int prev, da, db, pushes;
    bit started;
    pushes = 0;
    started = 1'b0;
    exp_d.delete();
    exp_ovf = 1'b0;
    prev = blk(1'b0, a, 0);
    for (int k = 1; k < 2000 && pushes < len; k++) begin
      da = blk(1'b0, a, k);
      db = blk(1'b1, a, k);
      if (!started) begin
        if (prev < trig && da >= trig) started = 1'b1;
        else prev = da;
      end
      if (started) begin
        if (r < 0 || pushes < DEPTH || (a + 4 + 4 * k) >= r) begin
          exp_d.push_back({W'(db), W'(da)});
          pushes++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic do_arm(input int len, input int trig);
    capture_len = 16'(len);
    trig_level  = W'(trig);
    arm = 1'b1;
    arm_cyc = cyc;
    got_d.delete();
    got_l.delete();
    done_cnt = 0;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max) begin
      tick();
      n++;
    end
    chk({tag, " done_seen"}, 64'(done_cnt != 0), 64'd1);
    ticks(3);
  endtask

  task automatic check_record(input string tag);
    chk({tag, " beats"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("%s data[%0d]", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      chk($sformatf("%s last[%0d]", tag, i), 64'(got_l[i]), 64'(i == exp_d.size() - 1));
    end
    chk({tag, " done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, " ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  logic [2*W-1:0] beat;
  int len_r, trig_r, r_cyc, n;

  initial begin
    m_if.ready = 1'b1;

    // Reset state
    rst = 1'b1;
    ticks(3);
    chk("rst valid", 64'(m_if.valid), 64'd0);
    chk("rst last", 64'(m_if.last), 64'd0);
    chk("rst data", 64'(m_if.data), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst ovf", 64'(ovf), 64'd0);
    chk("rst otr", 64'(otr_seen), 64'd0);
    chk("oe_n", 64'(adc_oe_n), 64'd0);
    chk("adc_clk_b", 64'(adc_clk_b), 64'(clk));
    rst = 1'b0;
    ticks(2);

    // Full-scale positive: A steps from min to max, B held at max
    mode = 0; cval_a = 14'h0000; cval_b = 14'h3FFF;
    ticks(6);
    do_arm(3, 8191);
    ticks(10);
    cval_a = 14'h3FFF;
    wait_done("fs_pos", 400);
    build_model(arm_cyc, 3, 8191, -1);
    check_record("fs_pos");
    beat = (got_d.size() > 0) ? got_d[0] : '0;
    chk("fs_pos literal", 64'(beat), 64'({14'h1FFF, 14'h1FFF}));

    // Full-scale negative appears in the tail of a record
    cval_a = 14'h0000; cval_b = 14'h0000;
    ticks(6);
    do_arm(8, 8191);
    ticks(10);
    cval_a = 14'h3FFF;
    ticks(12);
    cval_a = 14'h0000;
    wait_done("fs_neg", 400);
    build_model(arm_cyc, 8, 8191, -1);
    check_record("fs_neg");
    beat = (got_d.size() > 0) ? got_d[0] : '0;
    chk("fs_neg first", 64'(beat), 64'({14'h2000, 14'h1FFF}));
    beat = (got_d.size() > 0) ? got_d[got_d.size() - 1] : '0;
    chk("fs_neg last", 64'(beat), 64'({14'h2000, 14'h2000}));

    // Ramp trigger at 100, five pairs, sink always ready
    mode = 1; ramp_v = 0;
    ticks(2);
    do_arm(5, 100);
    wait_done("ramp", 600);
    build_model(arm_cyc, 5, 100, -1);
    check_record("ramp");

    // Randomized data, threshold, length and sink backpressure
    for (int it = 0; it < 3; it++) begin
      mode = 2; rnd_ready = 1'b1;
      ticks(3);
      len_r  = $urandom_range(1, 12);
      trig_r = int'($urandom_range(0, 4000)) - 2000;
      do_arm(len_r, trig_r);
      wait_done("rand", 2000);
      build_model(arm_cyc, len_r, trig_r, -1);
      check_record($sformatf("rand%0d", it));
    end
    rnd_ready = 1'b0; m_if.ready = 1'b1;

    // Overflow: sink stalled past FIFO capacity, then released
    mode = 1; ramp_v = 0; m_if.ready = 1'b0;
    ticks(2);
    do_arm(20, 100);
    ticks(250);
    chk("ovf sticky", 64'(ovf), 64'd1);
    chk("ovf valid", 64'(m_if.valid), 64'd1);
    m_if.ready = 1'b1;
    r_cyc = cyc;
    wait_done("ovf", 600);
    build_model(arm_cyc, 20, 100, r_cyc);
    chk("ovf 20 beats", 64'(got_d.size()), 64'd20);
    check_record("ovf");

    // Abort with three entries queued
    ramp_v = 0; m_if.ready = 1'b0;
    ticks(2);
    do_arm(30, 100);
    n = 0;
    while (!m_if.valid && n < 400) begin tick(); n++; end
    chk("abort reached capture", 64'(m_if.valid), 64'd1);
    ticks(8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort valid", 64'(m_if.valid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    m_if.ready = 1'b1;
    ramp_v = 0;
    ticks(2);
    do_arm(4, 100);
    chk("rearm busy", 64'(busy), 64'd1);
    wait_done("rearm", 600);
    build_model(arm_cyc, 4, 100, -1);
    check_record("rearm");

    // Out-of-range: ignored in IDLE, sticky from CAPTURE until next arm
    adc_otr_b = 1'b1;
    tick();
    adc_otr_b = 1'b0;
    ticks(5);
    chk("otr idle", 64'(otr_seen), 64'd0);
    ramp_v = 0;
    ticks(2);
    do_arm(40, 100);
    n = 0;
    while (got_d.size() == 0 && n < 600) begin tick(); n++; end
    chk("otr reached capture", 64'(got_d.size() != 0), 64'd1);
    adc_otr_b = 1'b1;
    tick();
    adc_otr_b = 1'b0;
    ticks(4);
    chk("otr capture", 64'(otr_seen), 64'd2);
    wait_done("otr", 600);
    chk("otr held", 64'(otr_seen), 64'd2);
    build_model(arm_cyc, 40, 100, -1);
    check_record("otr");
    ramp_v = 0;
    ticks(2);
    do_arm(40, 100);
    chk("otr cleared by arm", 64'(otr_seen), 64'd0);

    // Reset mid-capture, then a zero-length arm is ignored
    n = 0;
    while (got_d.size() == 0 && n < 600) begin tick(); n++; end
    adc_otr_a = 1'b1;
    tick();
    adc_otr_a = 1'b0;
    ticks(3);
    rst = 1'b1;
    tick();
    chk("mid rst valid", 64'(m_if.valid), 64'd0);
    chk("mid rst data", 64'(m_if.data), 64'd0);
    chk("mid rst last", 64'(m_if.last), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst done", 64'(done), 64'd0);
    chk("mid rst otr", 64'(otr_seen), 64'd0);
    chk("mid rst ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    tick();
    capture_len = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("len0 busy now", 64'(busy), 64'd0);
    ticks(10);
    chk("len0 busy later", 64'(busy), 64'd0);

    chk("hold stability", 64'(stab_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
